// File: rtl/axi_lite_arbiter_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter with independent write and read grants.
// Define AXIL_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins); round-robin otherwise.
module axi_lite_arbiter_2to1 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic [ADDR_W-1:0]     m0_awaddr,
    input  logic [2:0]            m0_awprot,
    input  logic                  m0_awvalid,
    output logic                  m0_awready,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    input  logic                  m0_wvalid,
    output logic                  m0_wready,
    output logic [1:0]            m0_bresp,
    output logic                  m0_bvalid,
    input  logic                  m0_bready,
    input  logic [ADDR_W-1:0]     m0_araddr,
    input  logic [2:0]            m0_arprot,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    input  logic [ADDR_W-1:0]     m1_awaddr,
    input  logic [2:0]            m1_awprot,
    input  logic                  m1_awvalid,
    output logic                  m1_awready,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    input  logic                  m1_wvalid,
    output logic                  m1_wready,
    output logic [1:0]            m1_bresp,
    output logic                  m1_bvalid,
    input  logic                  m1_bready,
    input  logic [ADDR_W-1:0]     m1_araddr,
    input  logic [2:0]            m1_arprot,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    output logic [ADDR_W-1:0]     s_awaddr,
    output logic [2:0]            s_awprot,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    input  logic [1:0]            s_bresp,
    input  logic                  s_bvalid,
    output logic                  s_bready,
    output logic [ADDR_W-1:0]     s_araddr,
    output logic [2:0]            s_arprot,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    output logic [1:0]            wr_grant,
    output logic [1:0]            rd_grant
);

    typedef enum logic {W_IDLE, W_BUSY} wr_state_t;
    typedef enum logic {R_IDLE, R_BUSY} rd_state_t;

    wr_state_t  wr_state, wr_state_next;
    rd_state_t  rd_state, rd_state_next;
    logic [1:0] wr_req, rd_req, wr_grant_next, rd_grant_next;
    logic       aw_done, w_done, ar_done;
    logic       wr_last, rd_last;
    logic       wr_release, rd_release;

    // On a tie the master that did not win last time is chosen.
    function automatic logic [1:0] pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) return last ? 2'b01 : 2'b10;
        return req;
    endfunction

    assign wr_req     = {m1_awvalid, m0_awvalid};
    assign rd_req     = {m1_arvalid, m0_arvalid};
    assign wr_release = (wr_state == W_BUSY) && s_bvalid && s_bready;
    assign rd_release = (rd_state == R_BUSY) && s_rvalid && s_rready;

    always_comb begin
        wr_state_next = wr_state;
        wr_grant_next = wr_grant;
        case (wr_state)
            W_IDLE: if (wr_req != 2'b00) begin
                wr_state_next = W_BUSY;
                wr_grant_next = pick(wr_req, wr_last);
            end
            W_BUSY: if (wr_release) begin
                wr_state_next = W_IDLE;
                wr_grant_next = 2'b00;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_state_next = rd_state;
        rd_grant_next = rd_grant;
        case (rd_state)
            R_IDLE: if (rd_req != 2'b00) begin
                rd_state_next = R_BUSY;
                rd_grant_next = pick(rd_req, rd_last);
            end
            R_BUSY: if (rd_release) begin
                rd_state_next = R_IDLE;
                rd_grant_next = 2'b00;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_state <= W_IDLE;
            wr_grant <= 2'b00;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            rd_state <= R_IDLE;
            rd_grant <= 2'b00;
            ar_done  <= 1'b0;
        end else begin
            wr_state <= wr_state_next;
            wr_grant <= wr_grant_next;
            rd_state <= rd_state_next;
            rd_grant <= rd_grant_next;
            if (wr_release) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (s_awvalid && s_awready) aw_done <= 1'b1;
                if (s_wvalid && s_wready)   w_done  <= 1'b1;
            end
            if (rd_release)                  ar_done <= 1'b0;
            else if (s_arvalid && s_arready) ar_done <= 1'b1;
        end
    end

`ifdef AXIL_ARB_FIXED_PRIO_EN
    assign wr_last = 1'b1;
    assign rd_last = 1'b1;
`else
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_last <= 1'b1;
            rd_last <= 1'b1;
        end else begin
            if (wr_state == W_IDLE && wr_req != 2'b00) wr_last <= wr_grant_next[1];
            if (rd_state == R_IDLE && rd_req != 2'b00) rd_last <= rd_grant_next[1];
        end
    end
`endif

    // Write path: request channels muxed by the registered grant, masked once accepted.
    assign s_awaddr   = wr_grant[1] ? m1_awaddr : (wr_grant[0] ? m0_awaddr : '0);
    assign s_awprot   = wr_grant[1] ? m1_awprot : (wr_grant[0] ? m0_awprot : 3'b000);
    assign s_awvalid  = !aw_done && ((wr_grant[0] && m0_awvalid) || (wr_grant[1] && m1_awvalid));
    assign m0_awready = wr_grant[0] && !aw_done && s_awready;
    assign m1_awready = wr_grant[1] && !aw_done && s_awready;
    assign s_wdata    = wr_grant[1] ? m1_wdata : (wr_grant[0] ? m0_wdata : '0);
    assign s_wstrb    = wr_grant[1] ? m1_wstrb : (wr_grant[0] ? m0_wstrb : '0);
    assign s_wvalid   = !w_done && ((wr_grant[0] && m0_wvalid) || (wr_grant[1] && m1_wvalid));
    assign m0_wready  = wr_grant[0] && !w_done && s_wready;
    assign m1_wready  = wr_grant[1] && !w_done && s_wready;
    assign s_bready   = (wr_grant[0] && m0_bready) || (wr_grant[1] && m1_bready);
    assign m0_bvalid  = wr_grant[0] && s_bvalid;
    assign m1_bvalid  = wr_grant[1] && s_bvalid;
    assign m0_bresp   = wr_grant[0] ? s_bresp : 2'b00;
    assign m1_bresp   = wr_grant[1] ? s_bresp : 2'b00;

    // Read path
    assign s_araddr   = rd_grant[1] ? m1_araddr : (rd_grant[0] ? m0_araddr : '0);
    assign s_arprot   = rd_grant[1] ? m1_arprot : (rd_grant[0] ? m0_arprot : 3'b000);
    assign s_arvalid  = !ar_done && ((rd_grant[0] && m0_arvalid) || (rd_grant[1] && m1_arvalid));
    assign m0_arready = rd_grant[0] && !ar_done && s_arready;
    assign m1_arready = rd_grant[1] && !ar_done && s_arready;
    assign s_rready   = (rd_grant[0] && m0_rready) || (rd_grant[1] && m1_rready);
    assign m0_rvalid  = rd_grant[0] && s_rvalid;
    assign m1_rvalid  = rd_grant[1] && s_rvalid;
    assign m0_rdata   = rd_grant[0] ? s_rdata : '0;
    assign m1_rdata   = rd_grant[1] ? s_rdata : '0;
    assign m0_rresp   = rd_grant[0] ? s_rresp : 2'b00;
    assign m1_rresp   = rd_grant[1] ? s_rresp : 2'b00;

endmodule
